// File: rtl/mult16_seq.sv
// Sequential 16x16 -> 32 unsigned multiplier that time-shares one external 8x8 multiplier.
// Define MULT_PIPE_EN to register mul_p before accumulation (adds a DRAIN state, 6-cycle latency).
module mult16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic [2:0]  dbg_state
);

  // Handshake: i_start is accepted only in IDLE; o_busy is high from the cycle after
  // acceptance through the o_done cycle; o_done pulses once as o_product updates.
`ifdef MULT_PIPE_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PP0   = 3'd1,
    S_PP1   = 3'd2,
    S_PP2   = 3'd3,
    S_PP3   = 3'd4,
    S_DONE  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PP0  = 3'd1,
    S_PP1  = 3'd2,
    S_PP2  = 3'd3,
    S_PP3  = 3'd4,
    S_DONE = 3'd5
  } state_t;
`endif

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;
  logic [31:0] pp_term;
  logic [31:0] acc_next;

  assign dbg_state = state;

  always_comb begin
    mul_a = 8'h00;
    mul_b = 8'h00;
    case (state)
      S_PP0:   begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  end
      S_PP1:   begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
      S_PP2:   begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  end
      S_PP3:   begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
      default: begin mul_a = 8'h00;     mul_b = 8'h00;     end
    endcase
  end

`ifdef MULT_PIPE_EN
  logic [15:0] mul_q;

  // Each state adds the partial product issued one state earlier.
  always_comb begin
    pp_term = 32'h0;
    case (state)
      S_PP1:   pp_term = {16'h0, mul_q};
      S_PP2:   pp_term = {8'h0, mul_q, 8'h0};
      S_PP3:   pp_term = {8'h0, mul_q, 8'h0};
      S_DRAIN: pp_term = {mul_q, 16'h0};
      default: pp_term = 32'h0;
    endcase
  end
`else
  always_comb begin
    pp_term = 32'h0;
    case (state)
      S_PP0:   pp_term = {16'h0, mul_p};
      S_PP1:   pp_term = {8'h0, mul_p, 8'h0};
      S_PP2:   pp_term = {8'h0, mul_p, 8'h0};
      S_PP3:   pp_term = {mul_p, 16'h0};
      default: pp_term = 32'h0;
    endcase
  end
`endif

  assign acc_next = acc + pp_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a_q       <= 16'h0;
      b_q       <= 16'h0;
      acc       <= 32'h0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_product <= 32'h0;
`ifdef MULT_PIPE_EN
      mul_q     <= 16'h0;
`endif
    end else begin
`ifdef MULT_PIPE_EN
      mul_q <= mul_p;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            a_q    <= i_a;
            b_q    <= i_b;
            acc    <= 32'h0;
            o_busy <= 1'b1;
            state  <= S_PP0;
          end
        end
        S_PP0: begin
          acc   <= acc_next;
          state <= S_PP1;
        end
        S_PP1: begin
          acc   <= acc_next;
          state <= S_PP2;
        end
        S_PP2: begin
          acc   <= acc_next;
          state <= S_PP3;
        end
`ifdef MULT_PIPE_EN
        S_PP3: begin
          acc   <= acc_next;
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          acc       <= acc_next;
          o_product <= acc_next;
          o_done    <= 1'b1;
          state     <= S_DONE;
        end
`else
        S_PP3: begin
          acc       <= acc_next;
          o_product <= acc_next;
          o_done    <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult16_seq.sv
// Directed bench for mult16_seq: a cycle-level timeline model with an expected-product
// queue is compared every cycle, plus hand-computed literal checks per vector.
module tb_mult16_seq;

`ifdef MULT_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_product;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic [2:0]  dbg_state;

  mult16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .dbg_state (dbg_state)
  );

  // Stand-in for the external 8x8 combinational multiplier.
  assign mul_p = {8'h00, mul_a} * {8'h00, mul_b};

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: an accepted request keeps the block busy for LAT cycles, the last being done.
  logic [31:0] exp_q[$];
  int          m_cnt;
  logic [31:0] m_prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_prod <= 32'h0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (i_start === 1'b1) begin
        m_cnt <= LAT;
        exp_q.push_back({16'h0, i_a} * {16'h0, i_b});
      end
    end else begin
      if (m_cnt == 2) begin
        m_prod <= exp_q[0];
        exp_q.delete(0);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(o_busy), 32'(m_cnt != 0));
      chk("done", 32'(o_done), 32'(m_cnt == 1));
      chk("product", o_product, m_prod);
      if (m_cnt == 0) chk("idle_mul", {16'h0, mul_a, mul_b}, 32'h0);
      if (o_done === 1'b1) done_cnt++;
    end
  end

  // Driver tasks
  task automatic wait_done(input int s, input logic [31:0] exp, input string name, input int d0);
    int k;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (o_done === 1'b1) break;
    end
    if (o_done !== 1'b1) begin
      chk({name, "_timeout"}, 32'h0, 32'h1);
    end else begin
      chk({name, "_latency"}, 32'(cyc - s), 32'(LAT));
      chk({name, "_result"}, o_product, exp);
      @(negedge clk);
      chk({name, "_busy_after"}, 32'(o_busy), 32'h0);
      chk({name, "_pulses"}, 32'(done_cnt - d0), 32'h1);
    end
  endtask

  logic [15:0] map_exp [4];

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name, input bit chg, input bit chk_map);
    int s;
    int d0;
    @(posedge clk); #1;
    i_a = a; i_b = b; i_start = 1'b1;
    s = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    if (chg) begin i_a = 16'hFFFF; i_b = 16'hFFFF; end
    if (chk_map) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk($sformatf("%s_map%0d", name, j), {16'h0, mul_a, mul_b}, {16'h0, map_exp[j]});
      end
    end
    wait_done(s, exp, name, d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;
    map_exp[0] = 16'hFF00;
    map_exp[1] = 16'hFF01;
    map_exp[2] = 16'h0000;
    map_exp[3] = 16'h0001;
    reset = 1'b1; i_start = 1'b0; i_a = 16'h0; i_b = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_product", o_product, 32'h0);
    chk("rst_mul", {16'h0, mul_a, mul_b}, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(16'h1234, 16'h5678, 32'h06260060, "basic", 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max", 1'b0, 1'b0);
    run_op(16'h0000, 16'hABCD, 32'h00000000, "zero", 1'b0, 1'b0);
    run_op(16'h00FF, 16'h0100, 32'h0000FF00, "map", 1'b0, 1'b1);

    // Start held high while busy with different operands: ignored until IDLE.
    @(posedge clk); #1;
    i_a = 16'h0003; i_b = 16'h0005; i_start = 1'b1;
    s = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    i_a = 16'hFFFF; i_b = 16'h0002;
    wait_done(s, 32'h0000000F, "busy_ign", d0);
    s = cyc; d0 = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(s, 32'h0001FFFE, "after_busy", d0);

    // Reset asserted while in PP2
    @(posedge clk); #1;
    i_a = 16'h1111; i_b = 16'h2222; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_product", o_product, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'h0);
    run_op(16'h0010, 16'h0010, 32'h00000100, "post_rst", 1'b0, 1'b0);

    run_op(16'h0002, 16'h0002, 32'h00000004, "opchg", 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
